// File: rtl/data_access_assoc_pkg.sv
// Shared definitions for the set-associative cache bank data store:
// request opcodes, controller states and geometry helpers.
package data_access_assoc_pkg;

    typedef enum logic [1:0] {
        OpRead  = 2'd0,
        OpWrite = 2'd1,
        OpFill  = 2'd2,
        OpRsvd  = 2'd3
    } op_e;

    typedef enum logic {
        StInit = 1'b0,
        StRun  = 1'b1
    } state_e;

    function automatic int unsigned calc_lines_per_way(input int unsigned cache_size,
                                                       input int unsigned line_size,
                                                       input int unsigned num_banks,
                                                       input int unsigned num_ways);
        return cache_size / (line_size * num_banks * num_ways);
    endfunction

    function automatic int unsigned calc_set_bits(input int unsigned lines);
        return (lines > 1) ? $clog2(lines) : 1;
    endfunction

    localparam int unsigned LINES_PER_WAY = calc_lines_per_way(16384, 64, 4, 4);
    localparam int unsigned SET_BITS      = calc_set_bits(LINES_PER_WAY);

endpackage

// File: rtl/data_access_rsp_buf.sv
// Two-entry valid/ready response buffer with registered output and occupancy count.
module data_access_rsp_buf #(
    parameter int unsigned WIDTH = 512
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] data_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             push;
    logic             pop;

    assign pop_valid = (count_q != 2'd0);
    assign pop       = pop_valid && pop_ready;
    // Upstream flow control keeps the buffer from overflowing; the guard only
    // protects the stored entries should that ever be violated.
    assign push      = push_valid && ((count_q != 2'd2) || pop);
    assign pop_data  = data_q[rd_ptr_q];
    assign count     = count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) data_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/data_access_assoc.sv
// NUM_WAYS set-associative cache bank data store with byte-enabled per-way RAMs,
// a post-reset zeroing sequence and a stallable two-cycle read response path.
module data_access_assoc
    import data_access_assoc_pkg::*;
#(
    parameter int unsigned CACHE_SIZE      = 16384,
    parameter int unsigned CACHE_LINE_SIZE = 64,
    parameter int unsigned NUM_BANKS       = 4,
    parameter int unsigned NUM_WAYS        = 4,
    parameter bit          WRITE_ENABLE    = 1'b1,
    parameter bit          INIT_ENABLE     = 1'b1,
    localparam int unsigned LINES_PER_WAY  =
        calc_lines_per_way(CACHE_SIZE, CACHE_LINE_SIZE, NUM_BANKS, NUM_WAYS),
    localparam int unsigned SET_BITS       = calc_set_bits(LINES_PER_WAY),
    localparam int unsigned LINE_BITS      = CACHE_LINE_SIZE * 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [1:0]                 req_op,
    input  logic [SET_BITS-1:0]        req_set,
    input  logic [NUM_WAYS-1:0]        req_way,
    input  logic [CACHE_LINE_SIZE-1:0] req_byteen,
    input  logic [LINE_BITS-1:0]       req_wdata,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [LINE_BITS-1:0]       rsp_data,
    output logic                       init_done
);

    state_e                            state_q, state_d;
    logic [SET_BITS-1:0]               init_cnt_q, init_cnt_d;
    logic                              init_done_q;
    logic                              init_last;

    op_e                               op;
    logic                              req_fire;
    logic                              rd_en;
    logic                              wr_line;
    logic [2:0]                        occupancy;
    logic [1:0]                        buf_count;

    logic [SET_BITS-1:0]               ram_set;
    logic [NUM_WAYS-1:0]               ram_we;
    logic [CACHE_LINE_SIZE-1:0]        ram_be;
    logic [LINE_BITS-1:0]              ram_wdata;
    logic [NUM_WAYS-1:0][LINE_BITS-1:0] rd_way;

    logic                              s1_valid_q;
    logic [NUM_WAYS-1:0]               s1_way_q;
    logic [LINE_BITS-1:0]              rd_line;

    assign init_last = (init_cnt_q == SET_BITS'(LINES_PER_WAY - 1));
    assign init_done = init_done_q;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            StInit: begin
                init_cnt_d = init_cnt_q + SET_BITS'(1);
                if (init_last) begin
                    state_d    = StRun;
                    init_cnt_d = '0;
                end
            end
            StRun:   state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= INIT_ENABLE ? StInit : StRun;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= (state_d == StRun);
        end
    end

    // Reads in flight in stage 1 count against buffer space so a push always fits.
    assign occupancy = {1'b0, buf_count} + {2'b00, s1_valid_q};
    assign req_ready = (state_q == StRun) && (occupancy < 3'd2);
    assign op        = op_e'(req_op);
    assign req_fire  = req_valid && req_ready;
    assign rd_en     = req_fire && (op == OpRead);
    assign wr_line   = req_fire && ((op == OpFill) || (WRITE_ENABLE && (op == OpWrite)));

    always_comb begin
        ram_set   = req_set;
        ram_wdata = req_wdata;
        ram_be    = '1;
        ram_we    = '0;
        if (state_q == StInit) begin
            ram_set   = init_cnt_q;
            ram_wdata = '0;
            ram_we    = '1;
        end else if (wr_line) begin
            ram_we = req_way;
            if (op == OpWrite) ram_be = req_byteen;
        end
    end

    // Only one request per cycle reaches the RAMs, so a read never shares a cycle with
    // a write; a read one cycle after a write already sees the updated array.
    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        logic [LINE_BITS-1:0] mem [LINES_PER_WAY];
        logic [LINE_BITS-1:0] rd_q;

        always_ff @(posedge clk) begin
            if (ram_we[w]) begin
                for (int b = 0; b < CACHE_LINE_SIZE; b++) begin
                    if (ram_be[b]) mem[ram_set][b*8 +: 8] <= ram_wdata[b*8 +: 8];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rd_en) rd_q <= mem[ram_set];
        end

        assign rd_way[w] = rd_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_way_q   <= '0;
        end else begin
            s1_valid_q <= rd_en;
            if (rd_en) s1_way_q <= req_way;
        end
    end

    // Multi-hot selects return the OR of the chosen ways; no select returns zero.
    always_comb begin
        rd_line = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (s1_way_q[w]) rd_line = rd_line | rd_way[w];
        end
    end

    data_access_rsp_buf #(
        .WIDTH(LINE_BITS)
    ) u_rsp_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .push_valid(s1_valid_q),
        .push_data (rd_line),
        .pop_valid (rsp_valid),
        .pop_ready (rsp_ready),
        .pop_data  (rsp_data),
        .count     (buf_count)
    );

endmodule

// File: doc/data_access_assoc.md
Name: data_access_assoc

Overview:
- Next-generation cache bank data store: NUM_WAYS set-associative line storage, replacing the single-way, always-ready data access block.
- Accepts one request per cycle (read, write or fill) on a valid/ready port.
- Returns read data on a valid/ready response port through a 2-entry output buffer, so the bank pipeline can stall.
- Optional post-reset zero-initialisation FSM.

Parameters:
- CACHE_SIZE, 16384, bank-group cache size in bytes
- CACHE_LINE_SIZE, 64, line size in bytes
- NUM_BANKS, 4, number of banks; LINES_PER_WAY = CACHE_SIZE/(CACHE_LINE_SIZE*NUM_BANKS*NUM_WAYS)
- NUM_WAYS, 4, associativity (power of 2, ≥1)
- WRITE_ENABLE, 1, 0 = read/fill only; byteen is ignored and fills are whole-line
- INIT_ENABLE, 1, 1 = clear all lines to zero after reset

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&ready
- req_op  in  2  0=read, 1=write, 2=fill, 3=reserved (treated as no-op, accepted)
- req_set  in  SET_BITS  line index, SET_BITS = clog2(LINES_PER_WAY)
- req_way  in  NUM_WAYS  one-hot way select
- req_byteen  in  CACHE_LINE_SIZE  write byte enables
- req_wdata  in  CACHE_LINE_SIZE*8  write/fill data
- rsp_valid  out  1  read data valid
- rsp_ready  in  1  consumer ready
- rsp_data  out  CACHE_LINE_SIZE*8  read line
- init_done  out  1  high once initialisation has completed

Behaviour:
- Reset is asynchronous: rsp_valid=0, init_done=0, buffer empty, in-flight=0, FSM enters INIT (INIT_ENABLE=1) or RUN (INIT_ENABLE=0). RAM contents are not reset.
- FSM INIT:
  - counter walks sets 0..LINES_PER_WAY-1, one per cycle, writing zero to all ways.
  - req_ready=0.
  - At the last set: go to RUN, init_done=1 from the next cycle.
  - reset_n assertion mid-INIT restarts at set 0.
- FSM RUN: stays in RUN until reset. With INIT_ENABLE=0, init_done=1 from the first cycle after reset release.
- req_ready in RUN = (buffer_count + inflight_reads) < 2, where inflight_reads = stage-1 valid read (0 or 1). This guarantees the buffer never overflows.
- Read accepted at cycle T:
  - RAM is addressed at T; the stage-1 register holds valid, set and way at T+1.
  - At T+1 the data of the selected way is muxed and pushed into the buffer.
  - rsp_valid is high from T+2 at the earliest: registered buffer output, 2-cycle latency.
- Write accepted at T: RAM updated at the T clock edge, using byte enables on the selected way(s) only. Data is not reset and produces no response.
- Fill accepted at T: whole-line write (byteen forced to all-ones) to the selected way.
- Multi-hot req_way on write/fill writes every selected way. Multi-hot req_way on a read returns the OR of the selected ways. All-zero req_way on a read returns zero but still produces a response.
- Read-after-write: a read at T+1 to a set/way written at T must return the new data. Bypass with a byte-merge register when the RAM macro returns old data on read-during-write.
- Response buffer:
  - Pop when rsp_valid&rsp_ready; push and pop in the same cycle are legal, count unchanged.
  - Data order equals read acceptance order.
  - rsp_data is held stable while rsp_valid=1 and rsp_ready=0.
- With WRITE_ENABLE=0, op=1 is treated as a no-op and accepted.

Decomposition:
- Shared package (cache define header): LINES_PER_WAY, SET_BITS, op encodings READ/WRITE/FILL, and the INIT/RUN state encoding.
- Natural sub-module: data_access_rsp_buf, a 2-entry valid/ready skid buffer with count output.
- RAM instances: one byte-enabled single-port RAM per way, generated.

Test Plan:
- Reset with INIT_ENABLE=1, LINES_PER_WAY=16 -> req_ready=0 for 16 cycles, init_done=1 at cycle 17; then a read of set 5 way 2 -> rsp_data=0.
- Fill set 3 way 1 with 0xA5 pattern, next cycle read set 3 way 1 -> rsp_valid 2 cycles after accept, data=0xA5 pattern (bypass path).
- Write byteen=0x000F data 0x11223344 to set 3 way 1 after the fill, then read -> low 4 bytes 0x11223344, remaining bytes 0xA5.
- Hold rsp_ready=0 and issue 3 back-to-back reads -> 2 accepted, req_ready=0; release rsp_ready -> responses in order, third read accepted, no loss or duplication.
- Assert reset_n low mid-INIT at set 7 -> outputs return to reset values immediately; INIT restarts at set 0 and needs the full 16 cycles.
- Fill the same set in 4 ways with distinct values, read each way -> each value returned unaliased; read with req_way=0 -> one response with data=0.
